// File: rtl/fifo_stim_sequencer.sv
// Stimulus sequencer for the async-FIFO demo: turns synchronised slow-clock edges into
// single-cycle FIFO write/read strobes with an incrementing data pattern.
module fifo_stim_sequencer #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned BURST_LEN   = 16,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DATA_INIT   = 0
) (
  input  logic              clk_100MHz,
  input  logic              reset_n,
  input  logic              clk_10Hz,
  input  logic              clk_25Hz,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic              fifo_full,
  input  logic              fifo_empty,
  output logic              wr_en,
  output logic [DATA_W-1:0] wr_data,
  output logic              rd_en,
  output logic              busy,
  output logic              stall,
  output logic [CNT_W-1:0]  wr_count,
  output logic [CNT_W-1:0]  rd_count
);

  typedef enum logic [1:0] {
    StIdle,
    StFill,
    StDrain,
    StStream
  } state_e;

  localparam logic [CNT_W-1:0]  BurstLast = CNT_W'(BURST_LEN);
  localparam logic [DATA_W-1:0] PatInit   = DATA_W'(DATA_INIT);

  // Synchronisers and edge-detect history
  logic [SYNC_STAGES-1:0] sync_wr_q, sync_rd_q, sync_st_q;
  logic                   prev_wr_q, prev_rd_q, prev_st_q;
  logic                   wr_tick, rd_tick, start_lvl, start_rise;

  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      sync_wr_q <= '0;
      sync_rd_q <= '0;
      sync_st_q <= '0;
      prev_wr_q <= 1'b0;
      prev_rd_q <= 1'b0;
      prev_st_q <= 1'b0;
    end else begin
      sync_wr_q <= {sync_wr_q[SYNC_STAGES-2:0], clk_10Hz};
      sync_rd_q <= {sync_rd_q[SYNC_STAGES-2:0], clk_25Hz};
      sync_st_q <= {sync_st_q[SYNC_STAGES-2:0], start};
      prev_wr_q <= sync_wr_q[SYNC_STAGES-1];
      prev_rd_q <= sync_rd_q[SYNC_STAGES-1];
      prev_st_q <= sync_st_q[SYNC_STAGES-1];
    end
  end

  assign wr_tick    = sync_wr_q[SYNC_STAGES-1] & ~prev_wr_q;
  assign rd_tick    = sync_rd_q[SYNC_STAGES-1] & ~prev_rd_q;
  assign start_lvl  = sync_st_q[SYNC_STAGES-1];
  assign start_rise = start_lvl & ~prev_st_q;

  // Sequencer state
  state_e             state_q, state_d;
  logic [DATA_W-1:0]  pattern_q, pattern_d;
  logic [CNT_W-1:0]   burst_q, burst_d;
  logic               wr_en_d, rd_en_d, stall_d, busy_d;
  logic [DATA_W-1:0]  wr_data_d;
  logic [CNT_W-1:0]   wr_count_d, rd_count_d;
  logic               do_wr, do_rd, wr_blocked, rd_blocked;

  always_comb begin
    state_d    = state_q;
    pattern_d  = pattern_q;
    burst_d    = burst_q;
    wr_data_d  = wr_data;
    wr_en_d    = 1'b0;
    rd_en_d    = 1'b0;
    stall_d    = 1'b0;
    do_wr      = 1'b0;
    do_rd      = 1'b0;
    wr_blocked = 1'b0;
    rd_blocked = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_rise) begin
          burst_d = '0;
          unique case (mode)
            2'b00:   state_d = StFill;
            2'b01:   state_d = StDrain;
            2'b10:   state_d = StStream;
            default: state_d = StIdle;
          endcase
        end
      end
      StFill: begin
        if (!start_lvl) begin
          state_d = StIdle;
        end else if (wr_tick) begin
          if (fifo_full) begin
            wr_blocked = 1'b1;
          end else begin
            do_wr   = 1'b1;
            burst_d = burst_q + CNT_W'(1);
            if (burst_d == BurstLast) state_d = StIdle;
          end
        end
      end
      StDrain: begin
        if (!start_lvl) begin
          state_d = StIdle;
        end else if (rd_tick) begin
          if (fifo_empty) begin
            rd_blocked = 1'b1;
          end else begin
            do_rd   = 1'b1;
            burst_d = burst_q + CNT_W'(1);
            if (burst_d == BurstLast) state_d = StIdle;
          end
        end
      end
      StStream: begin
        if (!start_lvl) begin
          state_d = StIdle;
        end else begin
          do_wr      = wr_tick & ~fifo_full;
          wr_blocked = wr_tick & fifo_full;
          do_rd      = rd_tick & ~fifo_empty;
          rd_blocked = rd_tick & fifo_empty;
        end
      end
      default: state_d = StIdle;
    endcase

    if (do_wr) begin
      wr_en_d   = 1'b1;
      wr_data_d = pattern_q;
      pattern_d = pattern_q + DATA_W'(1);
    end
    rd_en_d = do_rd;
    // Coincident write and read stalls collapse into a single pulse
    stall_d = wr_blocked | rd_blocked;
    busy_d  = (state_d != StIdle);

    wr_count_d = wr_count;
    if (do_wr && (wr_count != '1)) wr_count_d = wr_count + CNT_W'(1);
    rd_count_d = rd_count;
    if (do_rd && (rd_count != '1)) rd_count_d = rd_count + CNT_W'(1);
  end

  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      pattern_q <= PatInit;
      burst_q   <= '0;
      wr_en     <= 1'b0;
      wr_data   <= '0;
      rd_en     <= 1'b0;
      busy      <= 1'b0;
      stall     <= 1'b0;
      wr_count  <= '0;
      rd_count  <= '0;
    end else begin
      state_q   <= state_d;
      pattern_q <= pattern_d;
      burst_q   <= burst_d;
      wr_en     <= wr_en_d;
      wr_data   <= wr_data_d;
      rd_en     <= rd_en_d;
      busy      <= busy_d;
      stall     <= stall_d;
      wr_count  <= wr_count_d;
      rd_count  <= rd_count_d;
    end
  end

endmodule

// File: tb/tb_fifo_stim_sequencer.sv
// Scoreboard bench for fifo_stim_sequencer: stimulus queues expected strobes with their
// cycle of arrival; a monitor pops and compares whenever a strobe or stall appears.
module tb_fifo_stim_sequencer;

  typedef struct {
    bit         wr;
    bit         rd;
    bit         st;
    logic [7:0] data;
    int         cyc;
  } ev_t;

  logic clk_100MHz = 1'b0;
  logic reset_n = 1'b0;
  logic clk_10Hz = 1'b0, clk_25Hz = 1'b0, start = 1'b0;
  logic [1:0] mode = 2'b00;
  logic fifo_full = 1'b0, fifo_empty = 1'b0;
  logic wr_en, rd_en, busy, stall;
  logic [7:0] wr_data;
  logic [15:0] wr_count, rd_count;

  logic start4 = 1'b0, c25_4 = 1'b0, full4 = 1'b0, empty4 = 1'b0;
  logic [1:0] mode4 = 2'b10;
  logic wr_en4, rd_en4, busy4, stall4;
  logic [3:0] wr_data4, wr_count4, rd_count4;

  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;
  ev_t q[$];
  ev_t q4[$];

  always #5 clk_100MHz = ~clk_100MHz;
  always @(posedge clk_100MHz) cyc <= cyc + 1;

  fifo_stim_sequencer dut (
    .clk_100MHz (clk_100MHz),
    .reset_n    (reset_n),
    .clk_10Hz   (clk_10Hz),
    .clk_25Hz   (clk_25Hz),
    .start      (start),
    .mode       (mode),
    .fifo_full  (fifo_full),
    .fifo_empty (fifo_empty),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .rd_en      (rd_en),
    .busy       (busy),
    .stall      (stall),
    .wr_count   (wr_count),
    .rd_count   (rd_count)
  );

  fifo_stim_sequencer #(
    .DATA_W    (4),
    .CNT_W     (4),
    .BURST_LEN (8)
  ) dut4 (
    .clk_100MHz (clk_100MHz),
    .reset_n    (reset_n),
    .clk_10Hz   (clk_10Hz),
    .clk_25Hz   (c25_4),
    .start      (start4),
    .mode       (mode4),
    .fifo_full  (full4),
    .fifo_empty (empty4),
    .wr_en      (wr_en4),
    .wr_data    (wr_data4),
    .rd_en      (rd_en4),
    .busy       (busy4),
    .stall      (stall4),
    .wr_count   (wr_count4),
    .rd_count   (rd_count4)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk_100MHz);
  endtask

  // One slow-clock period; expected event lands SYNC_STAGES+1 = 3 cycles after the rise.
  task automatic tick(input bit w, input bit r, input bit f, input bit e,
                      input bit ew, input bit er, input bit es,
                      input logic [7:0] d, input bit to4);
    ev_t ev;
    fifo_full  = f;
    fifo_empty = e;
    if (w) clk_10Hz = 1'b1;
    if (r) clk_25Hz = 1'b1;
    ev = '{wr: ew, rd: er, st: es, data: d, cyc: cyc + 3};
    if (ew || er || es) begin
      if (to4) q4.push_back(ev);
      else q.push_back(ev);
    end
    wait_n(4);
    clk_10Hz   = 1'b0;
    clk_25Hz   = 1'b0;
    fifo_full  = 1'b0;
    fifo_empty = 1'b0;
    wait_n(4);
  endtask

  task automatic run(input logic [1:0] m);
    mode  = m;
    start = 1'b1;
    wait_n(5);
  endtask

  // Monitor
  initial begin
    ev_t e;
    forever begin
      @(negedge clk_100MHz);
      if (wr_en || rd_en || stall) begin
        if (q.size() == 0) begin
          check("unexpected_event", {29'd0, wr_en, rd_en, stall}, 32'd0);
        end else begin
          e = q.pop_front();
          check("event_cycle", cyc, e.cyc);
          check("event_kind", {29'd0, wr_en, rd_en, stall}, {29'd0, e.wr, e.rd, e.st});
          if (e.wr) check("wr_data", {24'd0, wr_data}, {24'd0, e.data});
        end
      end
      if (wr_en4 || rd_en4 || stall4) begin
        if (q4.size() == 0) begin
          check("unexpected_event4", {29'd0, wr_en4, rd_en4, stall4}, 32'd0);
        end else begin
          e = q4.pop_front();
          check("event_cycle4", cyc, e.cyc);
          check("event_kind4", {29'd0, wr_en4, rd_en4, stall4}, {29'd0, e.wr, e.rd, e.st});
          if (e.wr) check("wr_data4", {28'd0, wr_data4}, {28'd0, e.data[3:0]});
        end
      end
    end
  end

  initial begin
    wait_n(3);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_wr_count", {16'd0, wr_count}, 32'd0);
    check("reset_wr_data", {24'd0, wr_data}, 32'd0);
    reset_n = 1'b1;
    wait_n(3);

    // FILL: 16 writes, data 00..0F, then back to IDLE
    run(2'b00);
    check("fill_busy", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 16; i++) tick(1, 0, 0, 0, 1, 0, 0, 8'(i), 0);
    wait_n(2);
    check("fill_done_busy", {31'd0, busy}, 32'd0);
    check("fill_wr_count", {16'd0, wr_count}, 32'd16);
    start = 1'b0;
    wait_n(4);
    tick(1, 0, 0, 0, 0, 0, 0, 8'h00, 0); // idle tick: no strobe

    // FILL with full on ticks 3-4: 18 ticks complete the burst
    run(2'b00);
    begin
      logic [7:0] d;
      d = 8'h10;
      for (int t = 1; t <= 18; t++) begin
        if (t == 3 || t == 4) begin
          tick(1, 0, 1, 0, 0, 0, 1, 8'h00, 0);
        end else begin
          tick(1, 0, 0, 0, 1, 0, 0, d, 0);
          d++;
        end
      end
    end
    wait_n(2);
    check("gated_fill_busy", {31'd0, busy}, 32'd0);
    check("gated_fill_wr_count", {16'd0, wr_count}, 32'd32);
    start = 1'b0;
    wait_n(4);

    // DRAIN with empty FIFO, then two real reads, then abort
    run(2'b01);
    for (int i = 0; i < 3; i++) tick(0, 1, 0, 1, 0, 0, 1, 8'h00, 0);
    check("drain_empty_rd_count", {16'd0, rd_count}, 32'd0);
    check("drain_busy", {31'd0, busy}, 32'd1);
    tick(1, 0, 0, 0, 0, 0, 0, 8'h00, 0); // write tick ignored in DRAIN
    for (int i = 0; i < 2; i++) tick(0, 1, 0, 0, 0, 1, 0, 8'h00, 0);
    start = 1'b0;
    wait_n(5);
    check("drain_abort_busy", {31'd0, busy}, 32'd0);
    check("drain_rd_count", {16'd0, rd_count}, 32'd2);

    // STREAM: coincident strobes, mode change ignored, merged stall, timed abort
    run(2'b10);
    tick(1, 1, 0, 0, 1, 1, 0, 8'h20, 0);
    mode = 2'b00;
    tick(1, 0, 0, 0, 1, 0, 0, 8'h21, 0);
    tick(0, 1, 0, 0, 0, 1, 0, 8'h00, 0);
    tick(1, 1, 1, 1, 0, 0, 1, 8'h00, 0);
    check("stream_wr_count", {16'd0, wr_count}, 32'd34);
    check("stream_rd_count", {16'd0, rd_count}, 32'd4);
    start = 1'b0;
    wait_n(2);
    check("abort_busy_before", {31'd0, busy}, 32'd1);
    wait_n(1);
    check("abort_busy_after", {31'd0, busy}, 32'd0);
    wait_n(4);

    // Narrow instance: pattern wraps F->0, count saturates at 15
    start4 = 1'b1;
    wait_n(5);
    for (int i = 0; i < 20; i++) tick(1, 0, 0, 0, 1, 0, 0, 8'(i % 16), 1);
    check("sat_wr_count4", {28'd0, wr_count4}, 32'd15);
    start4 = 1'b0;
    wait_n(4);

    // Reset mid-STREAM with a tick in flight: nothing may emerge
    run(2'b10);
    clk_10Hz = 1'b1;
    wait_n(1);
    reset_n = 1'b0;
    start   = 1'b0;
    #1;
    check("rst_wr_en", {31'd0, wr_en}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_wr_count", {16'd0, wr_count}, 32'd0);
    check("rst_rd_count", {16'd0, rd_count}, 32'd0);
    wait_n(4);
    clk_10Hz = 1'b0;
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_wr_count4", {28'd0, wr_count4}, 32'd0);
    reset_n = 1'b1;
    wait_n(4);
    run(2'b00);
    tick(1, 0, 0, 0, 1, 0, 0, 8'h00, 0);
    start = 1'b0;
    wait_n(8);

    check("scoreboard_drained", q.size() + q4.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
